// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, state encodings and latency defaults for the MDU
//
// Purpose: single source for the op-field encoding used by decode and the MDU,
//          the MDU controller state encoding, and the default busy latencies.
// Ports:   none (package).
package mdu_defs;

   // 3-bit op field; 0 and 7 are both treated as NOP by the MDU.
   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - issue/result bundle between the pipeline and the MDU
//
// Purpose: groups the MDU issue strobe, operands and HI/LO/busy results.
// Ports:   start, op, rs_val, rt_val driven by the pipeline (master);
//          busy, hi, lo driven by the MDU (slave).
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, hi, lo
   );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO in IDLE. The arithmetic result
//          is computed combinationally from the operands and captured at accept;
//          a down-counter then models the latency, and HI/LO are updated only
//          on the edge that ends the busy window.
// Ports:   clk   - single clock, rising edge
//          reset - synchronous, active-high
//          bus   - mdu_if.slave: start/op/rs_val/rt_val in, busy/hi/lo out
module mdu
   import mdu_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   mdu_state_e    state;
   logic [CW-1:0] cnt;
   logic          busy_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic          res_wr;

   mdu_op_e            op_e;
   logic signed [31:0] rs_s;
   logic signed [31:0] rt_s;
   logic signed [31:0] rt_safe_s;
   logic [31:0]        rt_safe_u;
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        quo_s;
   logic [31:0]        rem_s;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;
   logic               div_zero;
   logic               div_ovf;

   always_comb begin
      op_e     = mdu_op_e'(bus.op);
      rs_s     = $signed(bus.rs_val);
      rt_s     = $signed(bus.rt_val);
      prod_s   = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
      prod_u   = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
      div_zero = (bus.rt_val == 32'd0);
      div_ovf  = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
      // Dividing by 1 instead of -1 in the overflow case yields exactly the
      // required 0x80000000 / 0 pair; substituting 1 for 0 keeps the divider
      // free of X, and the result is discarded anyway.
      rt_safe_s = (div_zero || div_ovf) ? 32'sd1 : rt_s;
      rt_safe_u = div_zero ? 32'd1 : bus.rt_val;
      quo_s     = rs_s / rt_safe_s;
      rem_s     = rs_s % rt_safe_s;
      quo_u     = bus.rs_val / rt_safe_u;
      rem_u     = bus.rs_val % rt_safe_u;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         res_wr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  case (op_e)
                     OP_MULT: begin
                        {res_hi, res_lo} <= prod_s;
                        res_wr <= 1'b1;
                        cnt    <= CW'(MULT_CYCLES);
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                     end
                     OP_MULTU: begin
                        {res_hi, res_lo} <= prod_u;
                        res_wr <= 1'b1;
                        cnt    <= CW'(MULT_CYCLES);
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                     end
                     OP_DIV: begin
                        res_lo <= quo_s;
                        res_hi <= rem_s;
                        res_wr <= !div_zero;
                        cnt    <= CW'(DIV_CYCLES);
                        busy_q <= 1'b1;
                        state  <= ST_DIV;
                     end
                     OP_DIVU: begin
                        res_lo <= quo_u;
                        res_hi <= rem_u;
                        res_wr <= !div_zero;
                        cnt    <= CW'(DIV_CYCLES);
                        busy_q <= 1'b1;
                        state  <= ST_DIV;
                     end
                     OP_MTHI: hi_q <= bus.rs_val;
                     OP_MTLO: lo_q <= bus.rs_val;
                     default: ;
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               // cnt holds the number of busy cycles left including this one.
               if (cnt == CW'(1)) begin
                  if (res_wr) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               cnt    <= '0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for the MDU with a cycle-level reference model
module tb_mdu;
   import mdu_defs::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mdu_if bus ();

   mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: an accepted long op is "in flight" from its accept
   // cycle until accept+N; its result is applied on the edge closing that cycle.
   int          cyc = 0;
   logic        m_ok = 1'b0;
   logic        m_active = 1'b0;
   int          m_end = 0;
   logic        m_wr = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] p_hi = 32'd0;
   logic [31:0] p_lo = 32'd0;

   always @(posedge clk) begin
      longint a_s, b_s, a_u, b_u, pr, q, r;
      a_s = longint'($signed(bus.rs_val));
      b_s = longint'($signed(bus.rt_val));
      a_u = longint'({32'd0, bus.rs_val});
      b_u = longint'({32'd0, bus.rt_val});
      if (reset) begin
         m_ok     <= 1'b1;
         m_active <= 1'b0;
         m_hi     <= 32'd0;
         m_lo     <= 32'd0;
      end else if (m_active) begin
         if (cyc == m_end) begin
            if (m_wr) begin
               m_hi <= p_hi;
               m_lo <= p_lo;
            end
            m_active <= 1'b0;
         end
      end else if (bus.start) begin
         case (bus.op)
            OP_MULT, OP_MULTU: begin
               pr = (bus.op == OP_MULT) ? a_s * b_s : a_u * b_u;
               p_hi     <= pr[63:32];
               p_lo     <= pr[31:0];
               m_wr     <= 1'b1;
               m_active <= 1'b1;
               m_end    <= cyc + NM;
            end
            OP_DIV, OP_DIVU: begin
               if (bus.rt_val != 32'd0) begin
                  q = (bus.op == OP_DIV) ? a_s / b_s : a_u / b_u;
                  r = (bus.op == OP_DIV) ? a_s % b_s : a_u % b_u;
                  p_lo <= q[31:0];
                  p_hi <= r[31:0];
               end
               m_wr     <= (bus.rt_val != 32'd0);
               m_active <= 1'b1;
               m_end    <= cyc + ND;
            end
            OP_MTHI: m_hi <= bus.rs_val;
            OP_MTLO: m_lo <= bus.rs_val;
            default: ;
         endcase
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         checks += 3;
         if (bus.busy !== m_active) begin
            failures++;
            $display("FAIL model_busy cyc=%0d got %b expected %b", cyc, bus.busy, m_active);
         end
         if (bus.hi !== m_hi) begin
            failures++;
            $display("FAIL model_hi cyc=%0d got %h expected %h", cyc, bus.hi, m_hi);
         end
         if (bus.lo !== m_lo) begin
            failures++;
            $display("FAIL model_lo cyc=%0d got %h expected %h", cyc, bus.lo, m_lo);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one start cycle, then scrambles operands to prove they were latched.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op     = op;
      bus.rs_val = a;
      bus.rt_val = b;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op     = OP_NOP;
      bus.rs_val = $urandom();
      bus.rt_val = $urandom();
   endtask

   task automatic wait_done(input string name, input int n_exp);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
      chk(name, 32'(n), 32'(n_exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start  = 1'b0;
      bus.op     = OP_NOP;
      bus.rs_val = 32'd0;
      bus.rt_val = 32'd0;
      reset      = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_hi", bus.hi, 32'd0);
      chk("reset_lo", bus.lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done("mult_busy", 5);
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu_busy", 5);
      chk("multu_hi", bus.hi, 32'h0000_0001);
      chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_busy", 10);
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);

      issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
      wait_done("divu_busy", 10);
      chk("divu_lo", bus.lo, 32'h7FFF_FFFC);
      chk("divu_hi", bus.hi, 32'h0000_0001);

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf_busy", 10);
      chk("div_ovf_lo", bus.lo, 32'h8000_0000);
      chk("div_ovf_hi", bus.hi, 32'h0000_0000);

      issue(OP_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
      chk("mthi_hi", bus.hi, 32'h1234_5678);
      issue(OP_DIVU, 32'd5, 32'd0);
      wait_done("div0_busy", 10);
      chk("div0_hi", bus.hi, 32'h1234_5678);
      chk("div0_lo", bus.lo, 32'h8000_0000);

      issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
      chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);

      issue(OP_MULT, 32'd7, 32'd6);
      @(negedge clk);
      bus.op     = OP_MULT;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd100;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op     = OP_NOP;
      wait_done("ignored_start_busy", 3);
      chk("ignored_start_hi", bus.hi, 32'd0);
      chk("ignored_start_lo", bus.lo, 32'd42);

      issue(OP_NOP, 32'hDEAD_BEEF, 32'd1);
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      chk("nop_busy", {31'd0, bus.busy}, 32'd0);
      chk("nop_hi", bus.hi, 32'd0);
      chk("nop_lo", bus.lo, 32'd42);

      issue(OP_DIV, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
      issue(OP_MULTU, 32'd3, 32'd4);
      wait_done("after_abort_busy", 5);
      chk("after_abort_lo", bus.lo, 32'h0000_000C);
      chk("after_abort_hi", bus.hi, 32'd0);

      reset = 1'b1;
      issue(OP_MULT, 32'd3, 32'd3);
      reset = 1'b0;
      chk("reset_vs_start_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_vs_start_lo", bus.lo, 32'd0);
      issue(OP_MULT, 32'd2, 32'd3);
      wait_done("post_reset_busy", 5);
      chk("post_reset_lo", bus.lo, 32'd6);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  issue strobe for the operation on op, one cycle.
REQ-006 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, others = NOP.
REQ-007 SHALL have port rs_val  input  32  first operand (dividend / multiplicand / MTHI-MTLO source).
REQ-008 SHALL have port rt_val  input  32  second operand (divisor / multiplier).
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port hi  output  32  HI register, consumed by the writeback mux feeding the register-file write data.
REQ-011 SHALL have port lo  output  32  LO register, consumed by the writeback mux feeding the register-file write data.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV with a down-counter loaded on accept.
REQ-013 SHALL accept start only in IDLE; start while busy is ignored, with no state, HI or LO change.
REQ-014 For MULT/MULTU/DIV/DIVU accepted in cycle T, SHALL latch operands at edge T, assert busy in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES), update HI/LO at the edge closing T+N, and return to IDLE with busy=0 in T+N+1.
REQ-015 HI/LO SHALL hold old values throughout the busy window; no partial result is ever visible.
REQ-016 MULT SHALL form the signed 64-bit product, MULTU the unsigned one; HI = bits 63:32, LO = bits 31:0.
REQ-017 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder with the dividend's sign; DIVU SHALL use unsigned semantics.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-019 A divisor of zero SHALL still run the full DIV_CYCLES busy window, then leave HI and LO unchanged.
REQ-020 MTHI/MTLO accepted in cycle T SHALL write rs_val to HI/LO at edge T, with no busy assertion.
REQ-021 An op value outside the defined set, or start with op = NOP, SHALL have no effect.
REQ-022 Operands SHALL be sampled only at accept; later rs_val/rt_val changes SHALL not affect the result.
REQ-023 busy SHALL be a registered output; the hazard unit combines start|busy for stall.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, counter 0, busy 0, HI 0, LO 0.
REQ-025 reset mid-operation SHALL abort the operation with no result written; reset SHALL override a simultaneous start.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-027 A shared package/header mdu_defs SHALL hold the op encodings, the state encodings and the default latency constants, shared with the controller.
REQ-028 Arithmetic SHALL be behavioural (64-bit product, / and %) registered at accept, with the counter only modelling latency; no sub-module is required.

Verification
REQ-029 MULT rs=0xFFFFFFFD (-3), rt=5 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-030 MULTU rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-031 DIV rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-032 MTHI 0x12345678, then DIVU rt=0 -> HI=0x12345678 is written immediately, and HI and LO are unchanged after the 10 busy cycles.
REQ-033 MULT issued, then a second MULT with different operands in busy cycle 2 -> the second is ignored and the result matches the first only.
REQ-034 DIV issued, reset pulsed in busy cycle 4 -> busy=0 and HI=LO=0 next cycle, and a new MULTU 3*4 then gives LO=0x0000000C.
